nv_nvdla_nocif_dram_read_ig_spt: RTL and testbench

//  Read-ingress split stage; sits directly downstream of the read-ingress arbiter.

---
 rtl/nv_nvdla_nocif_dram_read_ig_spt.sv | 66 ++++++
 tb/tb_nv_nvdla_nocif_dram_read_ig_spt.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_nocif_dram_read_ig_spt.sv
// nv_nvdla_nocif_dram_read_ig_spt: read-ingress split stage; a request whose atom span crosses a 256B boundary is issued as two requests
// Ports: nvdla_core_clk/nvdla_core_rst (async active-high); arb2spt_req_* request in (valid/ready/pd);
// spt2cvt_req_* registered request out (valid/ready/pd); spt2cvt_split_cnt saturating split count (NVDLA_NOCIF_SPT_CNT_EN only).
// pd: [AW-1:0] addr, [AW+2:AW] size, [AW+6:AW+3] axid, [AW+7] ftran, [AW+8] ltran, [AW+10:AW+9] rsvd
module nv_nvdla_nocif_dram_read_ig_spt #(
  parameter int AW = 64
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          arb2spt_req_valid,
  output logic          arb2spt_req_ready,
  input  logic [AW+10:0] arb2spt_req_pd,
  output logic          spt2cvt_req_valid,
  input  logic          spt2cvt_req_ready,
  output logic [AW+10:0] spt2cvt_req_pd
`ifdef NVDLA_NOCIF_SPT_CNT_EN
  ,
  output logic [15:0]   spt2cvt_split_cnt
`endif
);
  logic          out_vld, pend;
  logic [AW+10:0] out_pd, pend_pd, first_pd, second_pd;
  logic [AW-1:0] addr;
  logic [2:0]    s, size;
  logic [3:0]    e;
  logic          spl, in_acc, out_acc;
  assign addr = arb2spt_req_pd[AW-1:0];
  assign size = arb2spt_req_pd[AW+2:AW];
  assign s = addr[7:5];
  assign e = {1'b0, s} + {1'b0, size};
  assign spl = e[3];
  assign arb2spt_req_ready = !pend && (!out_vld || spt2cvt_req_ready);
  assign in_acc = arb2spt_req_valid && arb2spt_req_ready;
  assign out_acc = out_vld && spt2cvt_req_ready;
  assign spt2cvt_req_valid = out_vld;
  assign spt2cvt_req_pd = out_pd;
  // First piece runs to the end of the 256B block; second starts at the next block and carries the remainder.
  assign first_pd = {arb2spt_req_pd[AW+10:AW+9], 1'b0, arb2spt_req_pd[AW+7:AW+3], ~s, addr};
  assign second_pd = {arb2spt_req_pd[AW+10:AW+8], 1'b0, arb2spt_req_pd[AW+6:AW+3], e[2:0],
                      addr[AW-1:8] + 1'b1, 8'h0};
  // in_acc implies !pend, so the pend-drain and input-load branches never collide.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      out_vld <= 1'b0;
      pend <= 1'b0;
    end else if (out_acc && pend) begin
      pend <= 1'b0;
    end else if (in_acc) begin
      out_vld <= 1'b1;
      pend <= spl;
    end else if (out_acc) begin
      out_vld <= 1'b0;
    end
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (out_acc && pend) out_pd <= pend_pd;
    else if (in_acc) out_pd <= spl ? first_pd : arb2spt_req_pd;
    if (in_acc && spl) pend_pd <= second_pd;
  end
`ifdef NVDLA_NOCIF_SPT_CNT_EN
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) spt2cvt_split_cnt <= 16'h0;
    else if (in_acc && spl && spt2cvt_split_cnt != 16'hFFFF) spt2cvt_split_cnt <= spt2cvt_split_cnt + 16'h1;
  end
`endif
endmodule

// File: tb/tb_nv_nvdla_nocif_dram_read_ig_spt.sv
// tb_nv_nvdla_nocif_dram_read_ig_spt: scoreboard bench for the read-ingress split stage
module tb_nv_nvdla_nocif_dram_read_ig_spt;
  localparam int AW = 64;
  localparam int PW = AW + 11;
  logic clk = 0, rst = 1, iv = 0, ir, ov, ordy = 1;
  logic [PW-1:0] ipd = '0, opd, held;
`ifdef NVDLA_NOCIF_SPT_CNT_EN
  logic [15:0] cnt;
`endif
  int cmp = 0, bad = 0, nsplit = 0, cyc = 0;
  bit hv = 0, rec = 0, rnd = 0;
  logic [PW-1:0] q[$];
  int acc_cyc[$];

  nv_nvdla_nocif_dram_read_ig_spt #(.AW(AW)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .arb2spt_req_valid(iv), .arb2spt_req_ready(ir), .arb2spt_req_pd(ipd),
    .spt2cvt_req_valid(ov), .spt2cvt_req_ready(ordy), .spt2cvt_req_pd(opd)
`ifdef NVDLA_NOCIF_SPT_CNT_EN
    , .spt2cvt_split_cnt(cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (rnd) #1 ordy = $urandom_range(0, 3) != 0;

  function automatic logic [PW-1:0] mk(input logic [AW-1:0] a, input int sz, input logic [3:0] id,
                                       input logic f, input logic l, input logic [1:0] r);
    mk = {r, l, f, id, 3'(sz), a};
  endfunction

  task automatic chk(input string n, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (hv && ov) chk("pd_stable", opd, held);
    hv = ov && !ordy;
    held = opd;
    if (ov && ordy) begin
      if (q.size() == 0) begin
        cmp++; bad++;
        $display("FAIL unexpected_out: got %h want none", opd);
      end else chk("out_pd", opd, q.pop_front());
      if (rec) acc_cyc.push_back(cyc);
    end
  end

  // Expected pieces derived from byte ranges: [a, a+len-1] split at the next 256B line.
  task automatic send(input logic [AW-1:0] a, input int sz, input logic [3:0] id,
                      input logic f, input logic l, input logic [1:0] r);
    logic [AW-1:0] e, b;
    int w;
    iv = 1;
    ipd = mk(a, sz, id, f, l, r);
    w = 0;
    @(negedge clk);
    while (!ir && w < 200) begin @(negedge clk); w++; end
    if (!ir) begin
      cmp++; bad++;
      $display("FAIL in_timeout: got ready=0 want ready=1");
    end else begin
      e = a + AW'((sz + 1) * 32) - 1;
      if (a[AW-1:8] != e[AW-1:8]) begin
        b = {a[AW-1:8], 8'h0} + 256;
        q.push_back(mk(a, int'((b - a) / 32) - 1, id, f, 1'b0, r));
        q.push_back(mk(b, int'((e - b) / 32), id, 1'b0, l, r));
        nsplit++;
      end else q.push_back(ipd);
    end
    @(posedge clk); #1 iv = 0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || ov) && w < 500) begin @(negedge clk); w++; end
    if (q.size() != 0) begin
      cmp++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", ov, 0);
    chk("rst_ready", ir, 1);
`ifdef NVDLA_NOCIF_SPT_CNT_EN
    chk("rst_cnt", cnt, 0);
`endif
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    send(64'h1000, 7, 4'h5, 1, 1, 2'b10);
    chk("lat_valid", ov, 1);
    drain();
    send(64'h10E0, 3, 4'hA, 1, 1, 2'b01);
    @(negedge clk) chk("split_ready_low", ir, 0);
    @(negedge clk) chk("split_ready_back", ir, 1);
    drain();
    ordy = 0;
    send(64'h10E0, 3, 4'h3, 1, 1, 2'b11);
    repeat (5) @(posedge clk);
    #1 ordy = 1;
    drain();
    rec = 1;
    for (int i = 0; i < 20; i++) send({$urandom, $urandom} & ~64'hFF, $urandom_range(0, 7), 4'(i), i[0], i[1], 2'(i));
    drain();
    rec = 0;
    chk("b2b_count", acc_cyc.size(), 20);
    for (int i = 1; i < acc_cyc.size(); i++) chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 1);
    send(64'hFFFF_FFFF_FFFF_FFE0, 1, 4'h7, 1, 1, 2'b00);
    drain();
    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send({$urandom, $urandom} & ~64'h1F, $urandom_range(0, 7), 4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
    end
    rnd = 0;
    @(posedge clk); #1 ordy = 1;
    drain();
`ifdef NVDLA_NOCIF_SPT_CNT_EN
    chk("split_cnt", cnt, PW'(nsplit));
`endif
    ordy = 0;
    send(64'h20C0, 5, 4'h1, 1, 1, 2'b01);
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", ov, 0);
    chk("midrst_ready", ir, 1);
`ifdef NVDLA_NOCIF_SPT_CNT_EN
    chk("midrst_cnt", cnt, 0);
`endif
    q.delete();
    hv = 0;
    nsplit = 0;
    @(posedge clk); #1 rst = 0; ordy = 1;
    send(64'h30E0, 2, 4'h2, 1, 1, 2'b10);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
